softmax_exp_arbiter: RTL and testbench
======================================

# softmax_exp_arbiter

Round-robin arbiter that shares one exponent unit (the softmax exp datapath, 32-bit float in, 32-bit result out) between `num_req` requesters, such as parallel softmax lanes. It captures one winning request into a registered issue slot, drives the exp unit through a valid/ready handshake, and records the requester ID in an in-order tag FIFO. Each returning result is routed back to the requester that issued it. It sits between the lane controllers and the single shared exp block.

## Interface
- `data_size`, 32, width of operand and result words
- `num_req`, 4, number of requesters (2..16)
- `tag_depth`, 4, maximum outstanding requests (power of two, includes the issue slot)
- `clock_i`  in  1  clock; all logic on rising edge
- `reset_i`  in  1  reset, asynchronous and active-high
- `req_valid_i`  in  num_req  per-requester request valid
- `req_data_i`  in  num_req*data_size  flattened operands; requester r in bits [r*data_size +: data_size]
- `req_ready_o`  out  num_req  one-hot grant; the request is accepted when valid and ready are both high at a clock edge
- `exp_req_valid_o`  out  1  issue slot holds an operand for the exp unit
- `exp_req_data_o`  out  data_size  operand to the exp unit
- `exp_req_ready_i`  in  1  exp unit accepts the operand
- `exp_rsp_valid_i`  in  1  exp unit result valid; one-cycle pulse, results return in issue order
- `exp_rsp_data_i`  in  data_size  exp unit result
- `rsp_valid_o`  out  num_req  one-hot result strobe, one cycle wide
- `rsp_data_o`  out  data_size  result, shared by all requesters
- `busy_o`  out  1  tag FIFO not empty
- `err_o`  out  1  sticky: a response arrived with the tag FIFO empty

## Operation
- **Grant.** A grant is issued only when the issue slot is empty, the tag FIFO is not full, and at least one `req_valid_i` is high.
  - `req_ready_o` is combinational from `req_valid_i`, the slot state, the FIFO count and the priority pointer.
  - It never depends on `exp_req_ready_i`.
- **Round-robin.** A pointer `last` holds the most recently granted index; reset value is `num_req-1`.
  - Search order is `last+1`, `last+2`, … and wraps modulo `num_req`.
  - `last` updates only on an accepted grant.
- **On accept.**
  - The winner's operand is loaded into the slot and `exp_req_valid_o` is set.
  - The winner's index is pushed into the tag FIFO.
- **Issue handshake.** The slot clears when `exp_req_valid_o && exp_req_ready_i`. The slot state is IDLE or LOADED:
  - IDLE -> LOADED on grant.
  - LOADED -> IDLE on the issue handshake.
- **Response.**
  - On `exp_rsp_valid_i`, the tag FIFO is popped.
  - On the next cycle, `rsp_valid_o[tag]` and `rsp_data_o = exp_rsp_data_i` are driven.
  - If the FIFO is empty, the response is dropped, `err_o` is set, and `rsp_valid_o` stays 0.
- **FIFO full.** No grant is issued, even if a pop happens in the same cycle.
- **Simultaneous push and pop** with the FIFO non-full and non-empty: the count is unchanged.
- **Reset.**
  - All outputs are 0: `req_ready_o`, `exp_req_valid_o`, `exp_req_data_o`, `rsp_valid_o`, `rsp_data_o`, `busy_o`, `err_o`.
  - The slot goes to IDLE and the FIFO empties.
  - Reset mid-operation discards in-flight tags. The exp unit must be reset on the same `reset_i`; otherwise any stale response after reset sets `err_o`.
- **Width.** `data_size` is passed through unmodified. The tag width is `$clog2(num_req)` and the FIFO count width is `$clog2(tag_depth)+1`.

## Timing
- Accept at edge N -> `exp_req_valid_o` high from cycle N+1.
- The slot holds its data stable until the handshake.
- Maximum grant rate is one per two cycles, because the slot must empty before the next grant.
- `exp_rsp_valid_i` at edge M -> `rsp_valid_o` and `rsp_data_o` valid for one cycle after edge M. `rsp_data_o` holds its value afterwards.
- `busy_o` is registered and reflects the FIFO count after each edge.
- `err_o` is set one cycle after the offending pulse and clears only on reset.

## Configuration
- **`SOFTMAX_EXP_ARB_FIXED_PRIO_EN` defined:** fixed priority; the lowest index always wins and the `last` pointer is not implemented.
- **Undefined (default):** round-robin as described above.

## Test plan
- **Single requester.** Reset; `req_valid_i=4'b0100` with operand 0x3F800000; exp unit ready, responds 3 cycles after issue with 0x402DF854 -> `req_ready_o=4'b0100`, issue next cycle, `rsp_valid_o=4'b0100` with 0x402DF854, `busy_o` returns to 0.
- **Round-robin fairness.** All four requesters valid continuously and the exp unit always ready -> grant order is 0,1,2,3,0,… with grants every 2 cycles. With `SOFTMAX_EXP_ARB_FIXED_PRIO_EN` -> always 0.
- **Back-pressure.**
  - Hold `exp_req_ready_i=0` for 10 cycles -> `exp_req_data_o` stable, no further grants.
  - Withhold responses until 4 requests are outstanding -> `req_ready_o=0` until the first response pops.
- **In-order routing.** Grant sequence 2,0,3; responses 0xA,0xB,0xC -> `rsp_valid_o` = `4'b0100`, then `4'b0001`, then `4'b1000` with matching data.
- **Spurious response.** `exp_rsp_valid_i` pulse with the FIFO empty -> `err_o=1` the next cycle, `rsp_valid_o=0`, `err_o` stays set until reset.
- **Reset mid-operation.** Assert `reset_i` asynchronously with 3 outstanding -> all outputs 0 immediately, `busy_o=0`; normal grants resume after release.

Source files
------------

// File: rtl/softmax_exp_arbiter.sv
// Shares one exp unit between num_req requesters through a one-entry issue slot and an in-order tag FIFO.
// Define SOFTMAX_EXP_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module softmax_exp_arbiter #(
   parameter int data_size = 32,
   parameter int num_req   = 4,
   parameter int tag_depth = 4
) (
   input  logic                         clock_i,
   input  logic                         reset_i,
   input  logic [num_req-1:0]           req_valid_i,
   input  logic [num_req*data_size-1:0] req_data_i,
   output logic [num_req-1:0]           req_ready_o,
   output logic                         exp_req_valid_o,
   output logic [data_size-1:0]         exp_req_data_o,
   input  logic                         exp_req_ready_i,
   input  logic                         exp_rsp_valid_i,
   input  logic [data_size-1:0]         exp_rsp_data_i,
   output logic [num_req-1:0]           rsp_valid_o,
   output logic [data_size-1:0]         rsp_data_o,
   output logic                         busy_o,
   output logic                         err_o
);
   localparam int tag_w = $clog2(num_req);
   localparam int ptr_w = $clog2(tag_depth);
   localparam int cnt_w = ptr_w + 1;

   // Handshake: a transfer happens on a rising edge where valid and ready are both high;
   // valid never waits for ready, and a source holds its data stable while valid and not ready.
   typedef enum logic {slot_idle, slot_loaded} slot_state_t;
   slot_state_t slot_state, slot_state_next;

   logic [tag_w-1:0] tag_mem [tag_depth];
   logic [ptr_w-1:0] wr_ptr, rd_ptr;
   logic [cnt_w-1:0] count, count_next;
   logic             fifo_full, fifo_empty;
   logic             found, accept, pop, spurious;
   logic [tag_w-1:0] grant_idx;

   assign fifo_full  = (count == cnt_w'(tag_depth));
   assign fifo_empty = (count == '0);
   assign accept     = !reset_i && (slot_state == slot_idle) && !fifo_full && found;
   assign pop        = exp_rsp_valid_i && !fifo_empty;
   assign spurious   = exp_rsp_valid_i && fifo_empty;

`ifdef SOFTMAX_EXP_ARB_FIXED_PRIO_EN
   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      for (int i = 0; i < num_req; i++) begin
         if (!found && req_valid_i[i]) begin
            found     = 1'b1;
            grant_idx = tag_w'(i);
         end
      end
   end
`else
   logic [tag_w-1:0] last;
   logic [num_req-1:0] shifted;
   int cand;

   // Search starts just after the most recent winner and wraps modulo num_req.
   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      cand      = 0;
      shifted   = '0;
      for (int k = 1; k <= num_req; k++) begin
         cand = int'(last) + k;
         if (cand >= num_req) cand = cand - num_req;
         shifted = req_valid_i >> cand;
         if (!found && shifted[0]) begin
            found     = 1'b1;
            grant_idx = tag_w'(cand);
         end
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i)     last <= tag_w'(num_req - 1);
      else if (accept) last <= grant_idx;
   end
`endif

   always_comb begin
      req_ready_o = '0;
      if (accept) req_ready_o = num_req'(1) << grant_idx;
   end

   // Slot FSM: state register, next-state logic, output logic.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) slot_state <= slot_idle;
      else         slot_state <= slot_state_next;
   end

   always_comb begin
      slot_state_next = slot_state;
      case (slot_state)
         slot_idle:   if (accept)          slot_state_next = slot_loaded;
         slot_loaded: if (exp_req_ready_i) slot_state_next = slot_idle;
         default:                          slot_state_next = slot_idle;
      endcase
   end

   always_comb begin
      exp_req_valid_o = (slot_state == slot_loaded);
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i)     exp_req_data_o <= '0;
      else if (accept) exp_req_data_o <= req_data_i[grant_idx*data_size +: data_size];
   end

   always_comb begin
      count_next = count;
      if (accept && !pop)      count_next = count + 1'b1;
      else if (!accept && pop) count_next = count - 1'b1;
   end

   always_ff @(posedge clock_i) begin
      if (accept) tag_mem[wr_ptr] <= grant_idx;
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         busy_o      <= 1'b0;
         err_o       <= 1'b0;
         rsp_valid_o <= '0;
         rsp_data_o  <= '0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         if (pop)    rd_ptr <= rd_ptr + 1'b1;
         count  <= count_next;
         busy_o <= (count_next != '0);
         if (spurious) err_o <= 1'b1;
         // A result with no matching tag is dropped; the data register keeps its last value.
         rsp_valid_o <= pop ? (num_req'(1) << tag_mem[rd_ptr]) : '0;
         if (pop) rsp_data_o <= exp_rsp_data_i;
      end
   end
endmodule

// File: tb/tb_softmax_exp_arbiter.sv
// Randomized bench for softmax_exp_arbiter: reference model of grant policy, slot and tag accounting,
// plus an in-order exp unit model; results are checked by a queue-based response monitor.
module tb_softmax_exp_arbiter;
   localparam int DW = 32;
   localparam int NR = 4;
   localparam int DEPTH = 4;
   localparam int W = NR + DW;

   logic             clock_i = 1'b0;
   logic             reset_i = 1'b1;
   logic [NR-1:0]    req_valid_i;
   logic [NR*DW-1:0] req_data_i;
   logic [NR-1:0]    req_ready_o;
   logic             exp_req_valid_o;
   logic [DW-1:0]    exp_req_data_o;
   logic             exp_req_ready_i;
   logic             exp_rsp_valid_i;
   logic [DW-1:0]    exp_rsp_data_i;
   logic [NR-1:0]    rsp_valid_o;
   logic [DW-1:0]    rsp_data_o;
   logic             busy_o;
   logic             err_o;

   softmax_exp_arbiter #(.data_size(DW), .num_req(NR), .tag_depth(DEPTH)) dut (
      .clock_i(clock_i), .reset_i(reset_i),
      .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
      .exp_req_valid_o(exp_req_valid_o), .exp_req_data_o(exp_req_data_o),
      .exp_req_ready_i(exp_req_ready_i), .exp_rsp_valid_i(exp_rsp_valid_i),
      .exp_rsp_data_i(exp_rsp_data_i), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
      .busy_o(busy_o), .err_o(err_o)
   );

   // clock / reset
   always #5 clock_i = ~clock_i;

   int n_tests = 0;
   int n_fail = 0;
   int cyc = 0;

   // scoreboard: expected {strobe, data} in result order
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_e;

   // reference model state
   logic          m_slot;
   logic [DW-1:0] m_slot_data;
   int            m_cnt;
   int            m_last;
   logic          m_err;
   logic          m_rsp_due;

   // requesters and exp unit model
   logic [NR-1:0] pend;
   logic [DW-1:0] opnd [NR];
   int            due_q[$];
   logic [DW-1:0] res_q[$];
   int            last_due;

   // knobs
   int   req_pct, rdy_pct, lat_min, lat_max;
   logic rsp_hold, spur;

   function automatic logic [DW-1:0] exp_fn(input logic [DW-1:0] x);
      if (x == 32'h3F80_0000) return 32'h402D_F854;
      return (x * 32'h9E37_79B1) ^ 32'h0F0F_1234;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
      end
   endtask

   function automatic logic [NR-1:0] model_ready(input logic [NR-1:0] v);
      logic [NR-1:0] r;
      r = '0;
      if (m_slot || m_cnt >= DEPTH || v == '0) return r;
`ifdef SOFTMAX_EXP_ARB_FIXED_PRIO_EN
      for (int i = 0; i < NR; i++) begin
         if (v[i]) begin r[i] = 1'b1; return r; end
      end
`else
      for (int k = 1; k <= NR; k++) begin
         if (v[(m_last + k) % NR]) begin r[(m_last + k) % NR] = 1'b1; return r; end
      end
`endif
      return r;
   endfunction

   task automatic model_reset();
      m_slot = 1'b0; m_slot_data = '0; m_cnt = 0; m_last = NR - 1;
      m_err = 1'b0; m_rsp_due = 1'b0; last_due = 0;
      exp_q.delete(); due_q.delete(); res_q.delete();
   endtask

   // driver: one clock cycle, entered and left at a falling edge
   task automatic step();
      logic [NR-1:0] v, er;
      logic real_rsp;
      int id, lat;
      for (int r = 0; r < NR; r++) begin
         if (!pend[r] && int'($urandom_range(99)) < req_pct) begin
            pend[r] = 1'b1;
            opnd[r] = $urandom;
         end
      end
      v = pend;
      req_valid_i = v;
      for (int r = 0; r < NR; r++) req_data_i[r*DW +: DW] = opnd[r];
      exp_req_ready_i = (int'($urandom_range(99)) < rdy_pct);
      exp_rsp_valid_i = 1'b0;
      real_rsp = 1'b0;
      if (!rsp_hold && due_q.size() > 0 && due_q[0] <= cyc) begin
         exp_rsp_valid_i = 1'b1;
         exp_rsp_data_i = res_q[0];
         real_rsp = 1'b1;
      end else if (spur && due_q.size() == 0 && m_cnt == 0) begin
         exp_rsp_valid_i = 1'b1;
         exp_rsp_data_i = $urandom;
         spur = 1'b0;
      end
      #1;
      check("busy", 64'(busy_o), 64'(m_cnt != 0));
      check("err", 64'(err_o), 64'(m_err));
      check("exp_valid", 64'(exp_req_valid_o), 64'(m_slot));
      if (m_slot) check("exp_data", 64'(exp_req_data_o), 64'(m_slot_data));
      check("rsp_strobe", 64'(rsp_valid_o != '0), 64'(m_rsp_due));
      er = model_ready(v);
      check("grant", 64'(req_ready_o), 64'(er));

      m_rsp_due = 1'b0;
      if (exp_rsp_valid_i) begin
         if (m_cnt > 0) begin m_cnt--; m_rsp_due = 1'b1; end
         else m_err = 1'b1;
      end
      if (real_rsp) begin
         void'(due_q.pop_front());
         void'(res_q.pop_front());
      end
      if (m_slot && exp_req_ready_i) begin
         m_slot = 1'b0;
         lat = $urandom_range(lat_max, lat_min);
         last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
         due_q.push_back(last_due);
         res_q.push_back(exp_fn(m_slot_data));
      end
      if (er != '0) begin
         id = 0;
         for (int i = 0; i < NR; i++) if (er[i]) id = i;
         m_cnt++;
         m_last = id;
         m_slot = 1'b1;
         m_slot_data = opnd[id];
         pend[id] = 1'b0;
         exp_q.push_back({er, exp_fn(opnd[id])});
      end
      @(posedge clock_i);
      @(negedge clock_i);
      cyc++;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"}, 64'(req_ready_o), 64'd0);
      check({tag, "_exp_valid"}, 64'(exp_req_valid_o), 64'd0);
      check({tag, "_exp_data"}, 64'(exp_req_data_o), 64'd0);
      check({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
      check({tag, "_rsp_data"}, 64'(rsp_data_o), 64'd0);
      check({tag, "_busy"}, 64'(busy_o), 64'd0);
      check({tag, "_err"}, 64'(err_o), 64'd0);
   endtask

   task automatic drain();
      req_pct = 0; rdy_pct = 100; rsp_hold = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (m_cnt == 0 && !m_slot && pend == '0 && due_q.size() == 0) break;
         step();
      end
      step();
      step();
      check("drain_queue", 64'(exp_q.size()), 64'd0);
   endtask

   // monitor: pops the scoreboard whenever a result strobe is presented
   always @(negedge clock_i) begin
      if (!reset_i && rsp_valid_o != '0) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rsp_unexpected cyc=%0d actual=%0h_%0h required=none", cyc, rsp_valid_o, rsp_data_o);
         end else begin
            mon_e = exp_q.pop_front();
            if ({rsp_valid_o, rsp_data_o} !== mon_e) begin
               n_fail++;
               $display("FAIL rsp cyc=%0d actual=%0h_%0h required=%0h_%0h",
                        cyc, rsp_valid_o, rsp_data_o, mon_e[W-1:DW], mon_e[DW-1:0]);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      req_valid_i = '0; req_data_i = '0; exp_req_ready_i = 1'b0;
      exp_rsp_valid_i = 1'b0; exp_rsp_data_i = '0;
      pend = '0;
      for (int r = 0; r < NR; r++) opnd[r] = '0;
      rsp_hold = 1'b0; spur = 1'b0;
      req_pct = 0; rdy_pct = 100; lat_min = 1; lat_max = 1;
      model_reset();

      // reset state, including grant masking while requests are raised
      repeat (2) @(negedge clock_i);
      req_valid_i = '1;
      #1;
      check_all_zero("reset");
      req_valid_i = '0;
      @(negedge clock_i);
      reset_i = 1'b0;

      // single requester, exp unit answering 3 cycles after issue
      lat_min = 3; lat_max = 3;
      pend[2] = 1'b1; opnd[2] = 32'h3F80_0000;
      repeat (10) step();

      // all requesters busy, exp unit always ready
      req_pct = 100; lat_min = 1; lat_max = 2;
      repeat (40) step();

      // issue back-pressure: slot must hold and no grant may be issued
      rdy_pct = 0;
      repeat (10) step();
      rdy_pct = 100;

      // responses withheld until the tag FIFO fills
      rsp_hold = 1'b1;
      repeat (15) step();
      rsp_hold = 1'b0;
      repeat (10) step();

      // random traffic
      req_pct = 30; rdy_pct = 60; lat_min = 1; lat_max = 6;
      repeat (400) step();
      drain();

      // response with nothing outstanding
      spur = 1'b1;
      repeat (4) step();
      req_pct = 40; rdy_pct = 80; lat_min = 1; lat_max = 4;
      repeat (30) step();

      // asynchronous reset with several tags outstanding
      rsp_hold = 1'b1; req_pct = 100; rdy_pct = 100;
      repeat (8) step();
      #2 reset_i = 1'b1;
      #1;
      check_all_zero("midreset");
      model_reset();
      rsp_hold = 1'b0;
      @(negedge clock_i);
      reset_i = 1'b0;
      req_pct = 50; rdy_pct = 70; lat_min = 1; lat_max = 5;
      repeat (60) step();
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
